// File: rtl/arm7tdmi_exception_seq.sv
// ARM7TDMI exception sequencer: latches synchronous aborts/traps, merges maskable IRQs,
// arbitrates by ARM priority and hands one registered exception entry to the core.
module arm7tdmi_exception_seq #(
  parameter int NUM_IRQ      = 8,
  parameter int ENTRY_CYCLES = 2,
  parameter int HIGH_VECTORS = 0,
  localparam int IDW         = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NUM_IRQ-1:0] i_irq_src,
  input  logic [NUM_IRQ-1:0] i_irq_mask,
  input  logic               i_fiq,
  input  logic               i_swi,
  input  logic               i_undefined_instr,
  input  logic               i_prefetch_abort,
  input  logic               i_data_abort,
  input  logic [31:0]        i_current_cpsr,
  input  logic [31:0]        i_current_pc,
  input  logic               i_entry_ack,
  output logic               o_exc_req,
  output logic [2:0]         o_exc_type,
  output logic [31:0]        o_exc_vector,
  output logic [31:0]        o_exc_cpsr,
  output logic [31:0]        o_exc_spsr,
  output logic [31:0]        o_exc_lr,
  output logic [IDW-1:0]     o_irq_id,
  output logic               o_busy
);

  localparam logic [2:0] T_NONE = 3'd0;
  localparam logic [2:0] T_UND  = 3'd1;
  localparam logic [2:0] T_SWI  = 3'd2;
  localparam logic [2:0] T_PABT = 3'd3;
  localparam logic [2:0] T_DABT = 3'd4;
  localparam logic [2:0] T_IRQ  = 3'd5;
  localparam logic [2:0] T_FIQ  = 3'd6;

  localparam logic [31:0] VEC_BASE = (HIGH_VECTORS == 1) ? 32'hFFFF_0000 : 32'h0000_0000;
  localparam logic [3:0]  CNT_LOAD = (ENTRY_CYCLES > 0) ? 4'(ENTRY_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_ENTER = 2'd2} state_t;

  function automatic logic [4:0] mode_of(input logic [2:0] t);
    case (t)
      T_UND:          mode_of = 5'h1B;
      T_SWI:          mode_of = 5'h13;
      T_PABT, T_DABT: mode_of = 5'h17;
      T_IRQ:          mode_of = 5'h12;
      T_FIQ:          mode_of = 5'h11;
      default:        mode_of = 5'h00;
    endcase
  endfunction

  function automatic logic [31:0] vec_off(input logic [2:0] t);
    case (t)
      T_UND:   vec_off = 32'h0000_0004;
      T_SWI:   vec_off = 32'h0000_0008;
      T_PABT:  vec_off = 32'h0000_000C;
      T_DABT:  vec_off = 32'h0000_0010;
      T_IRQ:   vec_off = 32'h0000_0018;
      T_FIQ:   vec_off = 32'h0000_001C;
      default: vec_off = 32'h0000_0000;
    endcase
  endfunction

  // Entry CPSR: new mode, IRQs disabled, ARM state; FIQ entry also disables FIQ.
  function automatic logic [31:0] entry_cpsr(input logic [31:0] c, input logic [2:0] t);
    logic [31:0] n;
    n      = c;
    n[4:0] = mode_of(t);
    n[5]   = 1'b0;
    n[7]   = 1'b1;
    n[6]   = (t == T_FIQ) ? 1'b1 : c[6];
    return n;
  endfunction

  state_t           r_state, w_state_nxt;
  logic             r_pend_swi, r_pend_und, r_pend_pabt, r_pend_dabt;
  logic [3:0]       r_cnt;
  logic [2:0]       r_exc_type;
  logic [31:0]      r_exc_vector, r_exc_cpsr, r_exc_spsr, r_exc_lr;
  logic [IDW-1:0]   r_irq_id;

  logic [NUM_IRQ-1:0] w_irq_act;
  logic               w_c_swi, w_c_und, w_c_pabt, w_c_dabt, w_c_irq, w_c_fiq;
  logic [2:0]         w_sel;
  logic [IDW-1:0]     w_irq_id;
  logic               w_load, w_ack_take;

  assign w_irq_act  = i_irq_src & ~i_irq_mask;
  assign w_c_swi    = r_pend_swi  | i_swi;
  assign w_c_und    = r_pend_und  | i_undefined_instr;
  assign w_c_pabt   = r_pend_pabt | i_prefetch_abort;
  assign w_c_dabt   = r_pend_dabt | i_data_abort;
  assign w_c_irq    = (|w_irq_act) & ~i_current_cpsr[7];
  assign w_c_fiq    = i_fiq & ~i_current_cpsr[6];
  assign w_load     = (r_state == S_IDLE) && (w_sel != T_NONE);
  assign w_ack_take = (r_state == S_REQ) && i_entry_ack;

  // Priority arbitration and lowest-index active IRQ source.
  always_comb begin
    w_sel    = T_NONE;
    w_irq_id = '0;
    if (w_c_dabt)      w_sel = T_DABT;
    else if (w_c_fiq)  w_sel = T_FIQ;
    else if (w_c_irq)  w_sel = T_IRQ;
    else if (w_c_pabt) w_sel = T_PABT;
    else if (w_c_und)  w_sel = T_UND;
    else if (w_c_swi)  w_sel = T_SWI;
    else               w_sel = T_NONE;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      w_irq_id = w_irq_act[i] ? IDW'(i) : w_irq_id;
    end
  end

  // Next-state logic for the request/ack/stall sequence.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_sel != T_NONE) w_state_nxt = S_REQ;
        else                 w_state_nxt = S_IDLE;
      end
      S_REQ: begin
        if (i_entry_ack) w_state_nxt = (ENTRY_CYCLES == 0) ? S_IDLE : S_ENTER;
        else             w_state_nxt = S_REQ;
      end
      S_ENTER: begin
        if (r_cnt == 4'd0) w_state_nxt = S_IDLE;
        else               w_state_nxt = S_ENTER;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Pending latches (set wins over clear), stall counter and frozen entry outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pend_swi   <= 1'b0;
      r_pend_und   <= 1'b0;
      r_pend_pabt  <= 1'b0;
      r_pend_dabt  <= 1'b0;
      r_cnt        <= 4'd0;
      r_exc_type   <= T_NONE;
      r_exc_vector <= 32'h0;
      r_exc_cpsr   <= 32'h0;
      r_exc_spsr   <= 32'h0;
      r_exc_lr     <= 32'h0;
      r_irq_id     <= '0;
    end else begin
      r_pend_swi  <= i_swi             | (r_pend_swi  & ~(w_ack_take && r_exc_type == T_SWI));
      r_pend_und  <= i_undefined_instr | (r_pend_und  & ~(w_ack_take && r_exc_type == T_UND));
      r_pend_pabt <= i_prefetch_abort  | (r_pend_pabt & ~(w_ack_take && r_exc_type == T_PABT));
      r_pend_dabt <= i_data_abort      | (r_pend_dabt & ~(w_ack_take && r_exc_type == T_DABT));
      if (w_ack_take)                              r_cnt <= CNT_LOAD;
      else if (r_state == S_ENTER && r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
      if (w_load) begin
        r_exc_type   <= w_sel;
        r_exc_vector <= VEC_BASE | vec_off(w_sel);
        r_exc_cpsr   <= entry_cpsr(i_current_cpsr, w_sel);
        r_exc_spsr   <= i_current_cpsr;
        r_exc_lr     <= i_current_pc + ((w_sel == T_DABT) ? 32'd8 : 32'd4);
        r_irq_id     <= w_irq_id;
      end
    end
  end

  assign o_exc_req    = (r_state == S_REQ);
  assign o_busy       = (r_state != S_IDLE);
  assign o_exc_type   = r_exc_type;
  assign o_exc_vector = r_exc_vector;
  assign o_exc_cpsr   = r_exc_cpsr;
  assign o_exc_spsr   = r_exc_spsr;
  assign o_exc_lr     = r_exc_lr;
  assign o_irq_id     = r_irq_id;

endmodule

// File: tb/tb_arm7tdmi_exception_seq.sv
// Bench for arm7tdmi_exception_seq: vector table through a scoreboard queue plus
// hand-written multi-cycle sequences; a high-vector instance shares the stimulus.
module tb_arm7tdmi_exception_seq;

  localparam int NUM_IRQ = 8;
  localparam int IDW     = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  irq_src = 8'h00, irq_mask = 8'h00;
  logic        fiq = 1'b0, swi = 1'b0, undef = 1'b0, pabt = 1'b0, dabt = 1'b0;
  logic [31:0] cpsr = 32'h0, pc = 32'h0;
  logic        ack = 1'b0;

  logic           req0, busy0, req1, busy1;
  logic [2:0]     typ0, typ1;
  logic [31:0]    vec0, ncpsr0, spsr0, lr0, vec1, ncpsr1, spsr1, lr1;
  logic [IDW-1:0] id0, id1;

  always #5 clk = ~clk;

  arm7tdmi_exception_seq #(.NUM_IRQ(NUM_IRQ), .ENTRY_CYCLES(2), .HIGH_VECTORS(0)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_irq_src(irq_src), .i_irq_mask(irq_mask), .i_fiq(fiq),
    .i_swi(swi), .i_undefined_instr(undef), .i_prefetch_abort(pabt), .i_data_abort(dabt),
    .i_current_cpsr(cpsr), .i_current_pc(pc), .i_entry_ack(ack),
    .o_exc_req(req0), .o_exc_type(typ0), .o_exc_vector(vec0), .o_exc_cpsr(ncpsr0),
    .o_exc_spsr(spsr0), .o_exc_lr(lr0), .o_irq_id(id0), .o_busy(busy0));

  arm7tdmi_exception_seq #(.NUM_IRQ(NUM_IRQ), .ENTRY_CYCLES(2), .HIGH_VECTORS(1)) u_dut_hv (
    .i_clk(clk), .i_rst(rst), .i_irq_src(irq_src), .i_irq_mask(irq_mask), .i_fiq(fiq),
    .i_swi(swi), .i_undefined_instr(undef), .i_prefetch_abort(pabt), .i_data_abort(dabt),
    .i_current_cpsr(cpsr), .i_current_pc(pc), .i_entry_ack(ack),
    .o_exc_req(req1), .o_exc_type(typ1), .o_exc_vector(vec1), .o_exc_cpsr(ncpsr1),
    .o_exc_spsr(spsr1), .o_exc_lr(lr1), .o_irq_id(id1), .o_busy(busy1));

  typedef struct {
    logic [31:0] cpsr;
    logic [31:0] pc;
    logic [7:0]  irq;
    logic [7:0]  mask;
    logic        fiq;
    logic [3:0]  ev;     // {dabt, pabt, undef, swi}
    logic        req;
    logic [2:0]  typ;
    logic [31:0] vec;
    logic [31:0] ncpsr;
    logic [31:0] lr;
    logic [2:0]  id;
  } vec_t;

  vec_t vt[12];
  vec_t exp_q[$];
  vec_t e;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic quiet();
    irq_src = 8'h00; irq_mask = 8'h00; fiq = 1'b0;
    swi = 1'b0; undef = 1'b0; pabt = 1'b0; dabt = 1'b0;
  endtask

  // Ack the pending entry and check busy stays high for exactly two cycles.
  task automatic ack_and_drain(input string nm);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk({nm, "_req_drop"}, {31'd0, req0}, 32'd0);
    chk({nm, "_busy1"}, {31'd0, busy0}, 32'd1);
    tick();
    chk({nm, "_busy2"}, {31'd0, busy0}, 32'd1);
    tick();
    chk({nm, "_busy_end"}, {31'd0, busy0}, 32'd0);
  endtask

  initial begin
    vt[0]  = '{32'h6000001F, 32'h00004000, 8'h00, 8'h00, 1'b0, 4'b1000,
               1'b1, 3'd4, 32'h10, 32'h60000097, 32'h00004008, 3'd0};
    vt[1]  = '{32'h0000001F, 32'h00000100, 8'h28, 8'h08, 1'b0, 4'b0000,
               1'b1, 3'd5, 32'h18, 32'h00000092, 32'h00000104, 3'd5};
    vt[2]  = '{32'h0000009F, 32'h00000100, 8'h28, 8'h08, 1'b0, 4'b0000,
               1'b0, 3'd0, 32'h00, 32'h00000000, 32'h00000000, 3'd0};
    vt[3]  = '{32'h0000001F, 32'h00000200, 8'h00, 8'h00, 1'b1, 4'b0000,
               1'b1, 3'd6, 32'h1C, 32'h000000D1, 32'h00000204, 3'd0};
    vt[4]  = '{32'h0000005F, 32'h00000200, 8'h00, 8'h00, 1'b1, 4'b0000,
               1'b0, 3'd0, 32'h00, 32'h00000000, 32'h00000000, 3'd0};
    vt[5]  = '{32'hF0000030, 32'h00008000, 8'h00, 8'h00, 1'b0, 4'b0010,
               1'b1, 3'd1, 32'h04, 32'hF000009B, 32'h00008004, 3'd0};
    vt[6]  = '{32'h00000010, 32'hFFFFFFFC, 8'h00, 8'h00, 1'b0, 4'b0001,
               1'b1, 3'd2, 32'h08, 32'h00000093, 32'h00000000, 3'd0};
    vt[7]  = '{32'h40000050, 32'h00001234, 8'h00, 8'h00, 1'b0, 4'b0100,
               1'b1, 3'd3, 32'h0C, 32'h400000D7, 32'h00001238, 3'd0};
    vt[8]  = '{32'h0000001F, 32'h00000010, 8'hF0, 8'h30, 1'b0, 4'b0000,
               1'b1, 3'd5, 32'h18, 32'h00000092, 32'h00000014, 3'd6};
    vt[9]  = '{32'h0000001F, 32'h00000010, 8'hFF, 8'hFF, 1'b0, 4'b0000,
               1'b0, 3'd0, 32'h00, 32'h00000000, 32'h00000000, 3'd0};
    vt[10] = '{32'h0000001F, 32'h00000500, 8'h04, 8'h00, 1'b1, 4'b1000,
               1'b1, 3'd4, 32'h10, 32'h00000097, 32'h00000508, 3'd2};
    vt[11] = '{32'h0000001F, 32'h00000600, 8'h04, 8'h00, 1'b1, 4'b0000,
               1'b1, 3'd6, 32'h1C, 32'h000000D1, 32'h00000604, 3'd2};

    tick();
    tick();
    chk("rst_req", {31'd0, req0}, 32'd0);
    chk("rst_busy", {31'd0, busy0}, 32'd0);
    chk("rst_type", {29'd0, typ0}, 32'd0);
    chk("rst_vec_hv", vec1, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      cpsr = vt[i].cpsr; pc = vt[i].pc; irq_src = vt[i].irq; irq_mask = vt[i].mask;
      fiq = vt[i].fiq; {dabt, pabt, undef, swi} = vt[i].ev;
      exp_q.push_back(vt[i]);
      tick();
      e = exp_q.pop_front();
      chk($sformatf("v%0d_req", i), {31'd0, req0}, {31'd0, e.req});
      if (e.req) begin
        chk($sformatf("v%0d_type", i), {29'd0, typ0}, {29'd0, e.typ});
        chk($sformatf("v%0d_vec", i), vec0, e.vec);
        chk($sformatf("v%0d_vec_hv", i), vec1, 32'hFFFF0000 | e.vec);
        chk($sformatf("v%0d_cpsr", i), ncpsr0, e.ncpsr);
        chk($sformatf("v%0d_spsr", i), spsr0, e.cpsr);
        chk($sformatf("v%0d_lr", i), lr0, e.lr);
        chk($sformatf("v%0d_id", i), {29'd0, id0}, {29'd0, e.id});
        quiet();
        ack_and_drain($sformatf("v%0d", i));
        chk($sformatf("v%0d_type_hold", i), {29'd0, typ0}, {29'd0, e.typ});
      end else begin
        chk($sformatf("v%0d_busy", i), {31'd0, busy0}, 32'd0);
        quiet();
      end
    end

    // Reset mid-handshake drops request, outputs and a pending SWI.
    cpsr = 32'h1F; pc = 32'hA000; dabt = 1'b1; swi = 1'b1;
    tick();
    quiet();
    chk("r_pre_type", {29'd0, typ0}, 32'd4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("r_req", {31'd0, req0}, 32'd0);
    chk("r_busy", {31'd0, busy0}, 32'd0);
    chk("r_type", {29'd0, typ0}, 32'd0);
    chk("r_vec", vec0, 32'd0);
    chk("r_cpsr", ncpsr0, 32'd0);
    chk("r_spsr", spsr0, 32'd0);
    chk("r_lr", lr0, 32'd0);
    chk("r_id", {29'd0, id0}, 32'd0);
    tick();
    tick();
    chk("r_swi_gone", {31'd0, req0}, 32'd0);

    // Priority chain DABT -> FIQ -> IRQ (IRQ held off by I=1 until cleared).
    cpsr = 32'h1F; pc = 32'h3000; dabt = 1'b1; fiq = 1'b1; irq_src = 8'h01;
    tick();
    dabt = 1'b0;
    chk("p_dabt", {29'd0, typ0}, 32'd4);
    ack_and_drain("p_dabt");
    tick();
    chk("p_fiq_req", {31'd0, req0}, 32'd1);
    chk("p_fiq_type", {29'd0, typ0}, 32'd6);
    chk("p_fiq_vec", vec0, 32'h1C);
    chk("p_fiq_cpsr", ncpsr0, 32'hD1);
    chk("p_fiq_lr", lr0, 32'h3004);
    fiq = 1'b0; cpsr = 32'h9F;
    ack_and_drain("p_fiq");
    tick();
    chk("p_irq_blocked", {31'd0, req0}, 32'd0);
    cpsr = 32'h1F;
    tick();
    chk("p_irq_type", {29'd0, typ0}, 32'd5);
    chk("p_irq_id", {29'd0, id0}, 32'd0);
    chk("p_irq_cpsr", ncpsr0, 32'h92);
    irq_src = 8'h00;
    tick();
    chk("p_irq_hold_req", {31'd0, req0}, 32'd1);
    chk("p_irq_hold_type", {29'd0, typ0}, 32'd5);
    ack_and_drain("p_irq");

    // SWI pulsed during PABT stall is latched and issued afterwards.
    cpsr = 32'h1F; pc = 32'h7000; pabt = 1'b1;
    tick();
    pabt = 1'b0;
    chk("l_pabt_vec_hv", vec1, 32'hFFFF000C);
    ack = 1'b1;
    tick();
    ack = 1'b0; swi = 1'b1;
    tick();
    swi = 1'b0;
    chk("l_enter_req", {31'd0, req0}, 32'd0);
    chk("l_enter_busy", {31'd0, busy0}, 32'd1);
    tick();
    chk("l_idle_req", {31'd0, req0}, 32'd0);
    tick();
    chk("l_swi_req", {31'd0, req1}, 32'd1);
    chk("l_swi_type", {29'd0, typ1}, 32'd2);
    chk("l_swi_vec_hv", vec1, 32'hFFFF0008);
    chk("l_swi_vec", vec0, 32'h08);
    chk("l_swi_lr", lr1, 32'h7004);
    ack_and_drain("l_swi");

    // UNDEF pulse on its own ack edge re-arms a second UNDEF request.
    cpsr = 32'h10; pc = 32'h9000; undef = 1'b1;
    tick();
    undef = 1'b0;
    chk("s_und1", {29'd0, typ0}, 32'd1);
    ack = 1'b1; undef = 1'b1;
    tick();
    ack = 1'b0; undef = 1'b0;
    tick();
    tick();
    chk("s_gap_req", {31'd0, req0}, 32'd0);
    tick();
    chk("s_und2_req", {31'd0, req0}, 32'd1);
    chk("s_und2_type", {29'd0, typ0}, 32'd1);
    chk("s_und2_lr", lr0, 32'h9004);
    ack_and_drain("s_und2");
    tick();
    chk("s_no_third", {31'd0, req0}, 32'd0);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("s_stray_ack_busy", {31'd0, busy0}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
